// File: rtl/mlp_pkg.sv
// Shared constants, types and FSM state codes for the MLP stream host.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mlp_pkg;

  localparam int IN_DIM  = 64;
  localparam int HID_DIM = 32;
  localparam int OUT_DIM = 10;
  localparam int LOGIT_W = 32;
  localparam int CLASS_W = 4;

  typedef logic signed [7:0]         feat_t;
  typedef logic signed [LOGIT_W-1:0] logit_t;
  typedef feat_t  [IN_DIM-1:0]       feat_vec_t;
  typedef logit_t [OUT_DIM-1:0]      logit_vec_t;

  // Host controller states
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] SEND  = 2'd3;

endpackage

// File: rtl/mlp_stream_host_if.sv
// Byte-in / word-out valid-ready stream pair between a producer/consumer and the host.
// Latency: n/a (wires only).
// Backpressure: s_ready throttles the byte stream, m_ready throttles result words.
interface mlp_stream_host_if;
  import mlp_pkg::*;

  logic        s_valid;
  logic        s_ready;
  feat_t       s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  // Host side: consumes bytes, produces result words
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  // Environment side: produces bytes, consumes result words
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/mlp_result_ser.sv
// Captures logits/pred on done and streams them as OUT_DIM+1 32-bit beats (pred first).
// Latency: m_valid rises the cycle after capture; one beat per accepted cycle.
// Backpressure: beat index and m_data/m_last hold while m_valid && !m_ready.
module mlp_result_ser
  import mlp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logit_vec_t         logits,
  input  logic [CLASS_W-1:0] pred,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [31:0]        m_data,
  output logic               m_last,
  output logic               pkt_done
);

  localparam int             BW        = $clog2(OUT_DIM + 1);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(OUT_DIM);

  logit_vec_t         logits_q;
  logic [CLASS_W-1:0] pred_q;
  logic [BW-1:0]      beat;

  // Snapshot the core results on done, then walk the beats as the sink accepts them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      logits_q <= '0;
      pred_q   <= '0;
      beat     <= '0;
      m_valid  <= 1'b0;
    end else if (capture) begin
      logits_q <= logits;
      pred_q   <= pred;
      beat     <= '0;
      m_valid  <= 1'b1;
    end else if (m_valid && m_ready) begin
      if (beat == BEAT_LAST) begin
        beat    <= '0;
        m_valid <= 1'b0;
      end else begin
        beat <= beat + 1'b1;
      end
    end
  end

  assign m_last   = m_valid && (beat == BEAT_LAST);
  assign pkt_done = m_last && m_ready;

  // Beat 0 carries the zero-extended class, beats 1..OUT_DIM the sign-extended logits
  always_comb begin
    m_data = 32'(pred_q);
    for (int i = 0; i < OUT_DIM; i++) begin
      if (beat == BW'(i + 1)) m_data = 32'(logits_q[i]);
    end
  end

endmodule

// File: rtl/mlp_stream_host.sv
// Host driver for the MLP core: assembles IN_DIM bytes, pulses start, waits for done, streams results.
// Latency: last byte at N -> mlp_start at N+1; done at D -> m_valid at D+1, last beat at D+OUT_DIM+1.
// Backpressure: s_ready only in LOAD; result beats stall on m_ready; timeout aborts a silent core.
module mlp_stream_host
  import mlp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  mlp_stream_host_if.slave   strm,
  output logic               mlp_start,
  output feat_vec_t          mlp_x,
  input  logit_vec_t         mlp_logits,
  input  logic [CLASS_W-1:0] mlp_pred,
  input  logic               mlp_done,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        sample_count
);

  localparam int            IW        = $clog2(IN_DIM);
  localparam logic [IW-1:0] IDX_LAST  = IW'(IN_DIM - 1);
  localparam int            TW        = $clog2(TIMEOUT_CYC);
  // Abort on the edge where the wait counter would reach TIMEOUT_CYC-1,
  // so the error flag lands exactly TIMEOUT_CYC cycles after the start pulse.
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 2);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic          s_hs;
  logic          capture;
  logic          pkt_done;

  assign strm.s_ready = (state == LOAD) && !rst;
  assign s_hs         = strm.s_valid && strm.s_ready;
  assign mlp_start    = (state == START);
  assign busy         = (state != LOAD);
  // Done outside WAIT (e.g. a level still high after SEND) must not re-capture
  assign capture      = (state == WAIT) && mlp_done;

  // Control FSM: byte count, start, timeout watch, packet completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      idx          <= '0;
      tcnt         <= '0;
      timeout_err  <= 1'b0;
      sample_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (s_hs) begin
            if (idx == '0) timeout_err <= 1'b0;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= START;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mlp_done) begin
            state <= SEND;
          end else if (tcnt == TCNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= LOAD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        SEND: begin
          if (pkt_done) begin
            sample_count <= sample_count + 16'd1;
            state        <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Feature vector assembly; frozen whenever s_ready is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mlp_x <= '0;
    end else if (s_hs) begin
      mlp_x[idx] <= strm.s_data;
    end
  end

  mlp_result_ser u_ser (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .logits   (mlp_logits),
    .pred     (mlp_pred),
    .m_valid  (strm.m_valid),
    .m_ready  (strm.m_ready),
    .m_data   (strm.m_data),
    .m_last   (strm.m_last),
    .pkt_done (pkt_done)
  );

endmodule

// File: tb/tb_mlp_stream_host.sv
// Bench for mlp_stream_host: mock core + result scoreboard + per-scenario tasks.
// Latency: n/a.
// Backpressure: m_ready driven per ready_mode (always, 1-in-3, random).
module tb_mlp_stream_host;
  import mlp_pkg::*;

  localparam int TMO = 4096;

  logic               clk = 1'b0;
  logic               rst;
  logic               mlp_start;
  feat_vec_t          mlp_x;
  logit_vec_t         mlp_logits;
  logic [CLASS_W-1:0] mlp_pred;
  logic               mlp_done;
  logic               busy;
  logic               timeout_err;
  logic [15:0]        sample_count;

  int checks   = 0;
  int failures = 0;

  mlp_stream_host_if io ();

  mlp_stream_host #(.TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .strm         (io),
    .mlp_start    (mlp_start),
    .mlp_x        (mlp_x),
    .mlp_logits   (mlp_logits),
    .mlp_pred     (mlp_pred),
    .mlp_done     (mlp_done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  // Scoreboard of {last, data} beats expected from the DUT
  logic [32:0] exp_q[$];
  int          exp_logit[OUT_DIM];
  int          exp_pred;

  // Mock core: done after done_delay cycles (never if <0), held done_hold cycles
  int done_delay = 600;
  int done_hold  = 1;
  bit done_force = 1'b0;
  int starts     = 0;
  int core_cnt   = 0;
  bit armed      = 1'b0;
  int hold_left  = 0;

  always @(negedge clk) begin
    if (rst) begin
      armed     = 1'b0;
      hold_left = 0;
    end else if (mlp_start) begin
      starts++;
      armed    = (done_delay >= 0);
      core_cnt = 0;
    end else if (armed) begin
      core_cnt++;
      if (core_cnt == done_delay) begin
        armed     = 1'b0;
        hold_left = done_hold;
        exp_q.push_back({1'b0, 32'(exp_pred)});
        for (int i = 0; i < OUT_DIM; i++)
          exp_q.push_back({(i == OUT_DIM - 1), 32'(exp_logit[i])});
      end
    end else if (hold_left > 0) begin
      hold_left--;
    end
    mlp_done = (hold_left > 0) || done_force;
  end

  // Result sink readiness
  int ready_mode = 0;
  int rcyc       = 0;
  always @(negedge clk) begin
    rcyc++;
    case (ready_mode)
      0:       io.m_ready = 1'b1;
      1:       io.m_ready = (rcyc % 3 == 0);
      default: io.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pop/compare each accepted beat, check hold while stalled
  int          beats_seen = 0;
  bit          prev_stall = 1'b0;
  logic [32:0] prev_beat;
  logic [32:0] e;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (io.m_valid !== 1'b1 || {io.m_last, io.m_data} !== prev_beat) begin
          failures++;
          $display("FAIL stall_hold got v=%b beat=%h exp v=1 beat=%h", io.m_valid, {io.m_last, io.m_data}, prev_beat);
        end
      end
      if (io.m_valid && io.m_ready) begin
        beats_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat got=%h exp=none", {io.m_last, io.m_data});
        end else begin
          e = exp_q.pop_front();
          if ({io.m_last, io.m_data} !== e) begin
            failures++;
            $display("FAIL beat got=%h exp=%h", {io.m_last, io.m_data}, e);
          end
        end
      end
      prev_stall = io.m_valid && !io.m_ready;
      prev_beat  = {io.m_last, io.m_data};
    end
  end

  // Stream IN_DIM bytes base+i; returns at the negedge after the last handshake
  task automatic send_sample(input int base, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < IN_DIM && guard < 5000) begin
      @(negedge clk);
      guard++;
      io.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      io.s_data  = 8'(base + i);
      #1;
      if (io.s_valid && io.s_ready) i++;
    end
    @(negedge clk);
    io.s_valid = 1'b0;
    #1;
    checks++;
    if (i != IN_DIM) begin
      failures++;
      $display("FAIL feed_bytes got=%0d exp=%0d", i, IN_DIM);
    end
  endtask

  task automatic set_core(input int delay, input int hold);
    done_delay = delay;
    done_hold  = hold;
    exp_pred   = 7;
    mlp_pred   = 4'd7;
    for (int i = 0; i < OUT_DIM; i++) begin
      exp_logit[i]  = 100 * i - 500;
      mlp_logits[i] = LOGIT_W'(exp_logit[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_mode = 2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      io.s_valid = 1'($urandom_range(0, 1));
      io.s_data  = 8'($urandom_range(0, 255));
      done_force = 1'($urandom_range(0, 1));
      mlp_pred   = 4'($urandom_range(0, 15));
      #3;
      checks++;
      if ({io.s_ready, io.m_valid, io.m_last, mlp_start, busy, timeout_err} !== 6'b0 ||
          io.m_data !== 32'd0 || sample_count !== 16'd0 || mlp_x !== '0) begin
        failures++;
        $display("FAIL reset_hold got rdy=%b v=%b l=%b st=%b busy=%b err=%b d=%h cnt=%0d exp all 0",
                 io.s_ready, io.m_valid, io.m_last, mlp_start, busy, timeout_err, io.m_data, sample_count);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    done_force = 1'b0;
    io.s_valid = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    #3;
    checks++;
    if (io.s_ready !== 1'b1 || busy !== 1'b0 || sample_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b busy=%b cnt=%0d exp 1 0 0", io.s_ready, busy, sample_count);
    end
  endtask

  task automatic test_nominal();
    int s0 = starts;
    int b0 = beats_seen;
    bit ok = 1'b1;
    int k = 0;
    set_core(600, 1);
    ready_mode = 0;
    send_sample(0, 1'b0);
    checks++;
    if (mlp_start !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse got=%b exp=1", mlp_start);
    end
    for (int i = 0; i < IN_DIM; i++) if (mlp_x[i] !== 8'(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mlp_x got=%h exp=ramp 00..3f", mlp_x);
    end
    @(negedge clk);
    checks++;
    if (mlp_start !== 1'b0) begin
      failures++;
      $display("FAIL start_width got=%b exp=0", mlp_start);
    end
    while (busy && k < 3000) begin @(negedge clk); k++; end
    #3;
    checks++;
    if (busy !== 1'b0 || starts - s0 != 1 || beats_seen - b0 != OUT_DIM + 1 ||
        sample_count !== 16'd1 || exp_q.size() != 0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL nominal_done got busy=%b starts=%0d beats=%0d cnt=%0d left=%0d err=%b exp 0 1 11 1 0 0",
               busy, starts - s0, beats_seen - b0, sample_count, exp_q.size(), timeout_err);
    end
  endtask

  task automatic test_backpressure();
    int b0 = beats_seen;
    bit ok = 1'b1;
    int k = 0;
    set_core(600, 1);
    ready_mode = 1;
    send_sample(0, 1'b1);
    for (int i = 0; i < IN_DIM; i++) if (mlp_x[i] !== 8'(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_mlp_x got=%h exp=ramp 00..3f", mlp_x);
    end
    while (busy && k < 3000) begin @(negedge clk); k++; end
    #3;
    checks++;
    if (busy !== 1'b0 || beats_seen - b0 != OUT_DIM + 1 || sample_count !== 16'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_done got busy=%b beats=%0d cnt=%0d left=%0d exp 0 11 2 0",
               busy, beats_seen - b0, sample_count, exp_q.size());
    end
    ready_mode = 0;
  endtask

  task automatic test_timeout();
    int  k = 0;
    bit  saw_valid = 1'b0;
    int  b0;
    set_core(-1, 1);
    send_sample(8'h40, 1'b0);
    while (!timeout_err && k < 5000) begin
      @(negedge clk);
      #1;
      k++;
      if (io.m_valid) saw_valid = 1'b1;
    end
    checks++;
    if (k != TMO || saw_valid || busy !== 1'b0 || io.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout got cyc=%0d mval=%b busy=%b rdy=%b exp %0d 0 0 1", k, saw_valid, busy, io.s_ready, TMO);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got=%b exp=1", timeout_err);
    end
    set_core(600, 1);
    b0 = beats_seen;
    k  = 0;
    send_sample(8'h10, 1'b0);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=0", timeout_err);
    end
    while (busy && k < 3000) begin @(negedge clk); k++; end
    #3;
    checks++;
    if (beats_seen - b0 != OUT_DIM + 1 || sample_count !== 16'd3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_recover got beats=%0d cnt=%0d left=%0d exp 11 3 0", beats_seen - b0, sample_count, exp_q.size());
    end
  endtask

  task automatic test_done_handling();
    int b0 = beats_seen;
    int k = 0;
    @(negedge clk);
    #1 done_force = 1'b1;
    @(negedge clk);
    #1 done_force = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    checks++;
    if (beats_seen != b0 || busy !== 1'b0 || io.s_ready !== 1'b1 || sample_count !== 16'd3) begin
      failures++;
      $display("FAIL done_in_load got beats=%0d busy=%b rdy=%b cnt=%0d exp 0 0 1 3", beats_seen - b0, busy, io.s_ready, sample_count);
    end
    set_core(100, 20);
    send_sample(8'h20, 1'b0);
    while (busy && k < 3000) begin @(negedge clk); k++; end
    repeat (30) @(negedge clk);
    #3;
    checks++;
    if (beats_seen - b0 != OUT_DIM + 1 || sample_count !== 16'd4 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL done_level got beats=%0d cnt=%0d busy=%b left=%0d exp 11 4 0 0",
               beats_seen - b0, sample_count, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int b0 = beats_seen;
    int k = 0;
    set_core(50, 1);
    send_sample(8'h05, 1'b0);
    while (beats_seen - b0 < 5 && k < 3000) begin @(negedge clk); #3; k++; end
    rst = 1'b1;
    #1;
    checks++;
    if (io.m_valid !== 1'b0 || sample_count !== 16'd0 || io.s_ready !== 1'b0 || beats_seen - b0 != 5) begin
      failures++;
      $display("FAIL mid_reset got v=%b cnt=%0d rdy=%b beats=%0d exp 0 0 0 5", io.m_valid, sample_count, io.s_ready, beats_seen - b0);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    checks++;
    if (mlp_x !== '0 || busy !== 1'b0 || io.s_ready !== 1'b1 || io.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_release got x_nz=%b busy=%b rdy=%b v=%b exp 0 0 1 0", |mlp_x, busy, io.s_ready, io.m_valid);
    end
    b0 = beats_seen;
    k  = 0;
    send_sample(8'h30, 1'b0);
    while (busy && k < 3000) begin @(negedge clk); k++; end
    #3;
    checks++;
    if (beats_seen - b0 != OUT_DIM + 1 || sample_count !== 16'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_fresh got beats=%0d cnt=%0d left=%0d exp 11 1 0", beats_seen - b0, sample_count, exp_q.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    io.s_valid = 1'b0;
    io.s_data  = '0;
    set_core(600, 1);
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_done_handling();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
